// File: rtl/program_loader.sv
// Streams a byte image into program memory: bytes are packed little-endian into
// instruction words and written at consecutive addresses from 0, core held in reset meanwhile.
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 8
`endif
`ifndef INSTRUCTION_SIZE
`define INSTRUCTION_SIZE 32
`endif
`ifndef PROG_MEMORY_SIZE
`define PROG_MEMORY_SIZE 256
`endif

module program_loader #(
    parameter int ADDRESS_SIZE = `ADDRESS_SIZE,
    parameter int DATA_SIZE    = `INSTRUCTION_SIZE,
    parameter int SIZE         = `PROG_MEMORY_SIZE
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    in_valid,
    input  logic [7:0]              in_data,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic                    mem_write_enable,
    output logic [ADDRESS_SIZE-1:0] mem_address,
    output logic [DATA_SIZE-1:0]    mem_data,
    output logic [ADDRESS_SIZE:0]   word_count,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic                    core_reset_n,
    output logic [1:0]              fsm_state
);

    localparam int BYTES_PER_WORD = (DATA_SIZE + 7) / 8;
    localparam int IDX_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int CNT_W          = ADDRESS_SIZE + 1;

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t                      state, state_next;
    logic [IDX_W-1:0]            byte_idx;
    logic [8*BYTES_PER_WORD-1:0] assembly;
    logic                        word_last;
    logic [CNT_W-1:0]            count_inc;
    logic                        accept;
    logic                        word_full;

    // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
    // the source must hold in_data/in_last stable until that happens.
    assign accept    = in_valid && in_ready;
    assign word_full = (byte_idx == IDX_W'(BYTES_PER_WORD - 1));
    assign count_inc = word_count + 1'b1;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            byte_idx   <= '0;
            assembly   <= '0;
            word_last  <= 1'b0;
            word_count <= '0;
            error      <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        byte_idx   <= '0;
                        assembly   <= '0;
                        word_last  <= 1'b0;
                        word_count <= '0;
                        error      <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        for (int k = 0; k < BYTES_PER_WORD; k++) begin
                            if (byte_idx == IDX_W'(k)) assembly[8*k +: 8] <= in_data;
                        end
                        byte_idx  <= byte_idx + 1'b1;
                        word_last <= in_last;
                    end
                end
                WRITE: begin
                    word_count <= count_inc;
                    assembly   <= '0;
                    byte_idx   <= '0;
                    word_last  <= 1'b0;
                    // A word carrying in_last ends cleanly even if it also fills memory.
                    if (word_last) error <= 1'b0;
                    else if (count_inc == CNT_W'(SIZE)) error <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = LOAD;
            LOAD:  if (accept && (word_full || in_last)) state_next = WRITE;
            WRITE: begin
                if (word_last || count_inc == CNT_W'(SIZE)) state_next = DONE;
                else state_next = LOAD;
            end
            DONE:  if (start) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    assign in_ready         = (state == LOAD);
    assign mem_write_enable = (state == WRITE);
    assign mem_address      = word_count[ADDRESS_SIZE-1:0];
    assign mem_data         = assembly[DATA_SIZE-1:0];
    assign busy             = (state == LOAD) || (state == WRITE);
    assign done             = (state == DONE);
    assign core_reset_n     = !busy;
    assign fsm_state        = state;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: 16-bit words, 4-word memory; writes are checked
// against an expected queue filled by the byte driver's own word model.
module tb_program_loader;

    localparam int A = 4;
    localparam int D = 16;
    localparam int S = 4;
    localparam int W = A + D;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_last;
    logic         in_ready;
    logic         mem_write_enable;
    logic [A-1:0] mem_address;
    logic [D-1:0] mem_data;
    logic [A:0]   word_count;
    logic         busy;
    logic         done;
    logic         error;
    logic         core_reset_n;
    logic [1:0]   fsm_state;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    logic prev_we = 1'b0;

    always #5 clock = ~clock;

    program_loader #(.ADDRESS_SIZE(A), .DATA_SIZE(D), .SIZE(S)) dut (
        .clock(clock), .reset(reset), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .mem_write_enable(mem_write_enable), .mem_address(mem_address), .mem_data(mem_data),
        .word_count(word_count), .busy(busy), .done(done), .error(error),
        .core_reset_n(core_reset_n), .fsm_state(fsm_state)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write monitor: every strobe must match the head of the expected queue.
    always @(negedge clock) begin
        if (reset === 1'b1 && mem_write_enable === 1'b1) begin
            logic [W-1:0] e;
            check_val("write_in_ready", in_ready, 0);
            check_val("strobe_len", prev_we, 0);
            if (exp_q.size() == 0) begin
                check_val("unexpected_write", {mem_address, mem_data}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check_val("write_addr", mem_address, e[W-1:D]);
                check_val("write_data", mem_data, e[D-1:0]);
            end
        end
        prev_we = (reset === 1'b1) && (mem_write_enable === 1'b1);
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check_val("start_in_ready", in_ready, 1);
        check_val("start_busy", busy, 1);
        check_val("start_core_reset_n", core_reset_n, 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic l, input bit gaps, output bit ok);
        in_valid = 1'b0;
        if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
        in_valid = 1'b1;
        in_data  = b;
        in_last  = l;
        ok = 1'b0;
        for (int t = 0; t < 8 && !ok; t++) begin
            @(negedge clock);
            if (in_ready) ok = 1'b1;
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (done !== 1'b1 && t < 100) begin @(posedge clock); #1; t++; end
        check_val("done_timeout", done, 1);
    endtask

    task automatic load_image(input logic [7:0] bytes[$], input bit use_last,
                              input bit gaps, input bit poke_start);
        int words;
        int k;
        logic [D-1:0] word;
        bit ok;
        bit is_last;
        bit last_seen;
        words = 0; k = 0; word = '0; last_seen = 1'b0;
        do_start();
        foreach (bytes[i]) begin
            is_last = use_last && (i == bytes.size() - 1);
            if (words == S) begin
                send_byte(bytes[i], is_last, 1'b0, ok);
                check_val("ovf_not_consumed", ok, 0);
                break;
            end
            send_byte(bytes[i], is_last, gaps, ok);
            check_val("byte_accepted", ok, 1);
            word[8*k +: 8] = bytes[i];
            k++;
            if (is_last) last_seen = 1'b1;
            if (k == 2 || is_last) begin
                exp_q.push_back({A'(words), word});
                words++;
                k = 0;
                word = '0;
            end
            if (poke_start && i == 0) begin
                start = 1'b1;
                @(posedge clock); #1;
                start = 1'b0;
                check_val("start_ignored_busy", busy, 1);
            end
        end
        wait_done();
        @(posedge clock); #1;
        check_val("word_count", word_count, words);
        check_val("error", error, (words == S) && !last_seen);
        check_val("done_in_ready", in_ready, 0);
        check_val("done_core_reset_n", core_reset_n, 1);
        check_val("done_busy", busy, 0);
        check_val("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        logic [7:0] img[$];
        bit ok;
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_val("rst_in_ready", in_ready, 0);
        check_val("rst_we", mem_write_enable, 0);
        check_val("rst_addr", mem_address, 0);
        check_val("rst_data", mem_data, 0);
        check_val("rst_count", word_count, 0);
        check_val("rst_flags", {busy, done, error, core_reset_n}, 4'b0001);
        reset = 1'b1;
        @(posedge clock); #1;

        img = '{8'h34, 8'h12, 8'h78, 8'h56};
        load_image(img, 1'b1, 1'b0, 1'b0);
        img = '{8'hAA, 8'hBB, 8'hCC};
        load_image(img, 1'b1, 1'b0, 1'b1);
        img = '{8'h7F};
        load_image(img, 1'b1, 1'b0, 1'b0);

        img = {};
        for (int i = 0; i < 7; i++) img.push_back(8'($urandom_range(0, 255)));
        load_image(img, 1'b1, 1'b0, 1'b0);
        load_image(img, 1'b1, 1'b1, 1'b0);

        // Image exactly filling memory, ending with in_last: clean finish.
        img = {};
        for (int i = 0; i < 8; i++) img.push_back(8'($urandom_range(0, 255)));
        load_image(img, 1'b1, 1'b1, 1'b0);

        img = {};
        for (int i = 0; i < 10; i++) img.push_back(8'(8'h10 + i));
        load_image(img, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        check_val("ovf_in_ready_held", in_ready, 0);
        check_val("ovf_error_held", error, 1);

        // Reset after three bytes: first word written, second aborted.
        do_start();
        exp_q.push_back({A'(0), 16'h2211});
        send_byte(8'h11, 1'b0, 1'b0, ok);
        send_byte(8'h22, 1'b0, 1'b0, ok);
        send_byte(8'h33, 1'b0, 1'b0, ok);
        check_val("pre_reset_accept", ok, 1);
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        check_val("mid_rst_in_ready", in_ready, 0);
        check_val("mid_rst_we", mem_write_enable, 0);
        check_val("mid_rst_count", word_count, 0);
        check_val("mid_rst_flags", {busy, done, error, core_reset_n}, 4'b0001);
        check_val("mid_rst_queue", exp_q.size(), 0);
        repeat (2) begin @(posedge clock); #1; end
        check_val("post_rst_idle_we", mem_write_enable, 0);

        img = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        load_image(img, 1'b1, 1'b1, 1'b0);

        repeat (3) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Streams a program image into the instruction memory: accepts bytes over a valid/ready handshake, assembles them little-endian into instruction words, and issues one write per word at consecutive addresses starting at 0. It sits between the host link (UART/debug receiver) and the write port of the program memory. While a load is in progress it holds the core in reset.

## Interface
- ADDRESS_SIZE, `ADDRESS_SIZE, width of the memory address
- DATA_SIZE, `INSTRUCTION_SIZE, instruction word width, must be ≥ 8
- SIZE, `PROG_MEMORY_SIZE, number of memory words, must be ≤ 2^ADDRESS_SIZE
- BYTES_PER_WORD, derived as ceil(DATA_SIZE/8), bytes per word, not overridable
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  begin a load, sampled in IDLE or DONE only
- in_valid  in  1  byte on in_data is valid
- in_data  in  8  stream byte
- in_last  in  1  qualifies the final byte of the image
- in_ready  out  1  loader accepts a byte this cycle
- mem_write_enable  out  1  one-cycle write strobe to program memory
- mem_address  out  ADDRESS_SIZE  write address
- mem_data  out  DATA_SIZE  write data
- word_count  out  ADDRESS_SIZE+1  words written in the current/last load
- busy  out  1  high in LOAD and WRITE
- done  out  1  high in DONE
- error  out  1  overflow flag, valid while done
- core_reset_n  out  1  low while busy, high otherwise

## Operation
- States: IDLE, LOAD, WRITE, DONE.
- IDLE: in_ready=0, done=0. start → LOAD; clear byte index, word_count, assembly register, error.
- LOAD: in_ready=1. A byte is accepted on in_valid&&in_ready and placed at bits [8k+7:8k] of the assembly register (k = byte index, little-endian); bits at or above DATA_SIZE are discarded. Once byte BYTES_PER_WORD-1 is accepted, or any byte is accepted with in_last=1 → WRITE. Unfilled bytes of a short final word are 0.
- WRITE: in_ready=0, mem_write_enable=1, mem_address=word_count[ADDRESS_SIZE-1:0], mem_data=assembly register. Next cycle: word_count+1; assembly register and byte index cleared. If the word carried in_last → DONE, error=0. Else if word_count+1 == SIZE → DONE, error=1 (overflow; remaining stream not consumed). Else → LOAD.
- DONE: in_ready=0, done=1, error held, word_count held. start → LOAD (new load, same clearing as IDLE).
- start is ignored in LOAD/WRITE. in_last on a byte that completes a full word produces exactly one write.
- mem_address/mem_data are don't-care when mem_write_enable=0 but must be stable (registered), never X after reset.

## Timing
- Reset (reset=0 at a rising edge): state=IDLE, in_ready=0, mem_write_enable=0, mem_address=0, mem_data=0, word_count=0, busy=0, done=0, error=0, core_reset_n=1. Reset mid-load aborts immediately; no further writes are issued; partially written memory is left as is.
- start sampled at edge N → in_ready=1 and busy=1, core_reset_n=0 from cycle N+1.
- Final byte of a word accepted at edge M → mem_write_enable high during cycle M+1 only; in_ready=1 again from cycle M+2 (unless DONE).
- Throughput: one word per BYTES_PER_WORD+1 cycles at full in_valid rate.
- DONE entered at edge after the final WRITE cycle; done rises and core_reset_n returns high the same cycle.
- in_valid with in_ready=0 is not consumed; the source holds the byte.

## Test plan
- DATA_SIZE=16: start, bytes 0x34,0x12,0x78,0x56(last) at full rate → writes 0x1234@0, 0x5678@1, each 1-cycle strobe, word_count=2, done=1, error=0.
- DATA_SIZE=16: bytes 0xAA,0xBB,0xCC(last) → writes 0xBBAA@0, 0x00CC@1; single-byte image 0x7F(last) → one write 0x007F@0.
- in_valid toggled randomly with gaps and stall cycles → same memory contents as full-rate run; no byte dropped or duplicated; in_ready=0 during every WRITE cycle.
- SIZE=4, DATA_SIZE=16: stream 10 bytes with no in_last → writes @0..3 only, DONE with error=1, in_ready=0 thereafter, word_count=4.
- Assert reset for 1 cycle after 3 bytes of a load → all outputs at reset values next cycle, no write strobe; new start then loads from address 0 normally.
- start pulsed during LOAD → ignored; start in DONE → second load overwrites from address 0, error cleared, word_count restarts at 0.
